snake_collision_checker: RTL and testbench
==========================================

# snake_collision_checker

Sequential consumer of the snake state bus produced by the snake movement logic. After each move, on a `start` pulse, it compares the new head against the food position, then against every body segment from index 1 to length-1, one segment per cycle. It reports `food_hit` and `self_hit` with a one-cycle `done` strobe, which the game controller uses to raise the grow-on-eat pulse or end the game.

## Interface
Parameters:
- `GRID_W`, 100: grid width in cells.
- `GRID_H`, 75: grid height in cells.
- `MAX_LEN`, 64: body array depth (segments).
- `POS_BITS`, 13: width of a flat cell index (y*GRID_W + x).

Ports:
- `clk`  in  1: single clock; all logic is on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle request; sampled only in IDLE.
- `snake_head`  in  POS_BITS: flat index of the head.
- `snake_length`  in  $clog2(MAX_LEN)+1: current segment count.
- `snake_body_flat`  in  POS_BITS*MAX_LEN: segment i occupies bits [i*POS_BITS +: POS_BITS]; segment 0 is the head.
- `food_pos`  in  POS_BITS: flat index of the food cell.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle strobe; results are valid in this cycle.
- `food_hit`  out  1: head equals food; held until the next accepted `start`.
- `self_hit`  out  1: head equals some segment i, 1 ≤ i < length; held until the next accepted `start`.

## Operation
- States: IDLE, FOOD, SCAN, DONE.
- IDLE, with `start`=1:
  - Capture `snake_head` into head_q and `food_pos` into food_q.
  - Capture the length as len_q = min(`snake_length`, MAX_LEN).
  - Clear `food_hit` and `self_hit`, set idx=1, go to FOOD.
- FOOD:
  - `food_hit` <= (head_q == food_q).
  - If len_q ≤ 1, go to DONE; otherwise go to SCAN.
- SCAN:
  - Compare head_q with segment[idx], read live from `snake_body_flat`.
  - On a match: `self_hit` <= 1 and go to DONE (early exit).
  - Else, if idx == len_q-1: go to DONE.
  - Else: idx <= idx+1.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored; it is not queued.
- Body bus: the bus is not snapshotted. The controller holds `update_snake` low while `busy`=1. Any change to the body bus during SCAN is an upstream protocol violation, and results are undefined.
- Width rules:
  - idx and len_q are $clog2(MAX_LEN)+1 bits.
  - A `snake_length` of 0 is treated as 1.
  - A `snake_length` above MAX_LEN is clamped to MAX_LEN.
  - Comparisons are full POS_BITS equality.
- Food hit and self hit may both be set in the same run; both flags are reported.
- Reset values: state=IDLE, `busy`=0, `done`=0, `food_hit`=0, `self_hit`=0, idx=1.
- A reset mid-run aborts immediately, with no `done`.

## Timing
- `start` is accepted at edge k; FOOD occupies cycle k+1.
- No hit, L=len_q ≥ 2: SCAN occupies cycles k+2 .. k+L; `done` is high in cycle k+L+1, so latency is L+1 cycles.
- Self hit at segment j: `done` is high in cycle k+j+2.
- L ≤ 1: `done` is high in cycle k+2.
- `busy` rises in cycle k+1 and falls after the DONE cycle.
- A new `start` can be accepted in the cycle after DONE.
- Worst-case latency with MAX_LEN=64 is 65 cycles, far below one move period.

## Structure
- Shared package `snake_pkg`:
  - GRID_W, GRID_H, MAX_LEN and POS_BITS constants.
  - LEN_BITS = $clog2(MAX_LEN)+1.
  - A pos_t typedef.
  - The checker state enum.
- Sub-module `snake_seg_mux`: a combinational selector from (body_flat, idx) to a POS_BITS segment. The game renderer reuses it.
- Everything else (FSM, counter, compare, result registers) lives in the top module.

## Test plan
- After reset, snake head 3750, body {3750, 3749, 3748, 3747}, length 4, food 3750, pulse `start` → `done` 5 cycles later, `food_hit`=1, `self_hit`=0.
- Same snake, food 0 → `done` at +5, both flags 0; `busy` is high for cycles +1..+5.
- Body {3750, 3749, 3750, 3747}, food 0 → early exit: `done` at +4, `self_hit`=1.
- Lengths 1 and 0 → `done` at +2, `self_hit`=0. Length 70 → clamped to 64, `done` at +65.
- Length 64, segment 63 equals head → `done` at +65, `self_hit`=1. A second `start` at +3 is ignored: only one `done` is produced.
- `rst` asserted at +3 of a run → next cycle `busy`=0, flags 0, no `done`. A fresh `start` then completes normally.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game datapath.
// The collision checker, its bus interface and the renderer all build on these.
package snake_pkg;
    localparam int GRID_W   = 100;
    localparam int GRID_H   = 75;
    localparam int MAX_LEN  = 64;
    localparam int POS_BITS = 13;
    localparam int LEN_BITS = $clog2(MAX_LEN) + 1;

    typedef logic [POS_BITS-1:0] pos_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FOOD,
        ST_SCAN,
        ST_DONE
    } chk_state_e;
endpackage

// File: rtl/snake_collision_checker_if.sv
// Snake state bus plus the collision-check request/result handshake.
// Handshake: start is a one-cycle request taken only while busy=0; done is a
// one-cycle strobe, and food_hit/self_hit stay valid until the next accepted start.
interface snake_collision_checker_if #(
    parameter int MAX_LEN  = snake_pkg::MAX_LEN,
    parameter int POS_BITS = snake_pkg::POS_BITS
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    logic                        start;
    logic [POS_BITS-1:0]         snake_head;
    logic [LEN_W-1:0]            snake_length;
    logic [POS_BITS*MAX_LEN-1:0] snake_body_flat;
    logic [POS_BITS-1:0]         food_pos;
    logic                        busy;
    logic                        done;
    logic                        food_hit;
    logic                        self_hit;

    modport master (
        output start, snake_head, snake_length, snake_body_flat, food_pos,
        input  busy, done, food_hit, self_hit
    );

    modport slave (
        input  start, snake_head, snake_length, snake_body_flat, food_pos,
        output busy, done, food_hit, self_hit
    );
endinterface

// File: rtl/snake_seg_mux.sv
// Combinational selector of one body segment out of the flat body bus.
// Indices at or beyond MAX_LEN return zero.
module snake_seg_mux
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = snake_pkg::MAX_LEN,
    parameter int POS_BITS = snake_pkg::POS_BITS,
    localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic [POS_BITS*MAX_LEN-1:0] body_flat,
    input  logic [LEN_W-1:0]            idx,
    output logic [POS_BITS-1:0]         seg
);
    always_comb begin
        seg = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx == LEN_W'(i)) begin
                seg = body_flat[i*POS_BITS +: POS_BITS];
            end
        end
    end
endmodule

// File: rtl/snake_collision_checker.sv
// Sequential head-vs-food and head-vs-body collision checker, one segment per cycle.
// Results are registered and held until the next accepted start.
module snake_collision_checker
    import snake_pkg::*;
#(
    parameter int GRID_W   = snake_pkg::GRID_W,
    parameter int GRID_H   = snake_pkg::GRID_H,
    parameter int MAX_LEN  = snake_pkg::MAX_LEN,
    parameter int POS_BITS = snake_pkg::POS_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    snake_collision_checker_if.slave  bus,
    output chk_state_e                state_dbg
);
    localparam int LEN_W = $clog2(MAX_LEN) + 1;

    generate
        if (GRID_W * GRID_H > (1 << POS_BITS)) begin : g_grid_check
            $error("snake_collision_checker: grid does not fit in POS_BITS");
        end
    endgenerate

    chk_state_e          state;
    logic [POS_BITS-1:0] head_q;
    logic [POS_BITS-1:0] food_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    idx;
    logic [LEN_W-1:0]    len_clamped;
    logic [POS_BITS-1:0] seg;
    logic                busy_r;
    logic                done_r;
    logic                food_hit_r;
    logic                self_hit_r;

    // Length 0 still means a head-only snake; oversize lengths saturate at the array depth.
    always_comb begin
        len_clamped = bus.snake_length;
        if (bus.snake_length == '0) begin
            len_clamped = LEN_W'(1);
        end else if (bus.snake_length > LEN_W'(MAX_LEN)) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    // Body is read live; the controller keeps it stable while busy.
    snake_seg_mux #(
        .MAX_LEN  (MAX_LEN),
        .POS_BITS (POS_BITS)
    ) u_seg_mux (
        .body_flat (bus.snake_body_flat),
        .idx       (idx),
        .seg       (seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            food_hit_r <= 1'b0;
            self_hit_r <= 1'b0;
            idx        <= LEN_W'(1);
            len_q      <= LEN_W'(1);
            head_q     <= '0;
            food_q     <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        head_q     <= bus.snake_head;
                        food_q     <= bus.food_pos;
                        len_q      <= len_clamped;
                        food_hit_r <= 1'b0;
                        self_hit_r <= 1'b0;
                        idx        <= LEN_W'(1);
                        busy_r     <= 1'b1;
                        state      <= ST_FOOD;
                    end
                end
                ST_FOOD: begin
                    food_hit_r <= (head_q == food_q);
                    if (len_q <= LEN_W'(1)) begin
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (seg == head_q) begin
                        self_hit_r <= 1'b1;
                        done_r     <= 1'b1;
                        state      <= ST_DONE;
                    end else if (idx == len_q - LEN_W'(1)) begin
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        idx <= idx + LEN_W'(1);
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.food_hit = food_hit_r;
    assign bus.self_hit = self_hit_r;
    assign state_dbg    = state;
endmodule

// File: tb/tb_snake_collision_checker.sv
// Directed plus small random bench for snake_collision_checker.
// Expected {latency, food_hit, self_hit} go into a queue at start and are popped at done.
module tb_snake_collision_checker;
    import snake_pkg::*;

    localparam int W    = 10;
    localparam int HEAD = 3750;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    chk_state_e state_dbg;

    snake_collision_checker_if bus ();

    snake_collision_checker dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int errors     = 0;
    int done_count = 0;
    logic [W-1:0] exp_q[$];

    always @(posedge clk) begin
        if (bus.done === 1'b1) done_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_seg(input int i, input int p);
        bus.snake_body_flat[i*POS_BITS +: POS_BITS] = POS_BITS'(p);
    endtask

    task automatic fill_body();
        set_seg(0, HEAD);
        for (int i = 1; i < MAX_LEN; i++) set_seg(i, 1000 + i);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic drive_start(input int len, input int food, input bit ef, input bit es, input int lat);
        bus.snake_head   = POS_BITS'(HEAD);
        bus.snake_length = LEN_BITS'(len);
        bus.food_pos     = POS_BITS'(food);
        exp_q.push_back({8'(lat), ef, es});
        pulse_start();
    endtask

    // Called at the falling edge of cycle +1 after the accepting edge.
    task automatic wait_done(input string tag, input int inject_at);
        int cyc = 1;
        int busy_cycles = 0;
        bit seen = 0;
        logic [W-1:0] e;
        while (cyc <= 200 && !seen) begin
            bus.start = (cyc == inject_at);
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1) seen = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        bus.start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL %s timeout: got no done expected done within 200 cycles", tag);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: got done expected no pending result", tag);
            return;
        end
        e = exp_q.pop_front();
        check({tag, " latency"}, cyc, 32'(e[W-1:2]));
        check({tag, " food_hit"}, 32'(bus.food_hit), 32'(e[1]));
        check({tag, " self_hit"}, 32'(bus.self_hit), 32'(e[0]));
        check({tag, " busy_cycles"}, busy_cycles, 32'(e[W-1:2]));
        @(negedge clk);
        check({tag, " busy_after"}, 32'(bus.busy), 0);
        check({tag, " done_after"}, 32'(bus.done), 0);
    endtask

    initial begin
        int dc;
        int len;
        int j;
        bit fh;
        bus.start           = 1'b0;
        bus.snake_head      = '0;
        bus.snake_length    = '0;
        bus.food_pos        = '0;
        bus.snake_body_flat = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", 32'(bus.busy), 0);
        check("reset done", 32'(bus.done), 0);
        check("reset food_hit", 32'(bus.food_hit), 0);
        check("reset self_hit", 32'(bus.self_hit), 0);
        check("reset state", 32'(state_dbg), 32'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Body {3750,3749,3748,3747}
        fill_body();
        set_seg(1, 3749);
        set_seg(2, 3748);
        set_seg(3, 3747);
        drive_start(4, HEAD, 1'b1, 1'b0, 5);
        wait_done("food_eat", 0);
        drive_start(4, 0, 1'b0, 1'b0, 5);
        wait_done("no_hit", 0);

        // Early exit on segment 2
        set_seg(2, HEAD);
        drive_start(4, 0, 1'b0, 1'b1, 4);
        wait_done("self_seg2", 0);

        // Short snakes
        drive_start(1, 0, 1'b0, 1'b0, 2);
        wait_done("len1", 0);
        drive_start(0, HEAD, 1'b1, 1'b0, 2);
        wait_done("len0", 0);

        // Oversize length clamps to MAX_LEN
        fill_body();
        drive_start(70, 0, 1'b0, 1'b0, MAX_LEN + 1);
        wait_done("len70", 0);

        // Last segment hit, with an ignored start mid-run
        set_seg(MAX_LEN - 1, HEAD);
        dc = done_count;
        drive_start(MAX_LEN, 0, 1'b0, 1'b1, MAX_LEN + 1);
        wait_done("seg63", 3);
        repeat (3) @(negedge clk);
        check("seg63 single done", done_count - dc, 1);
        check("seg63 idle", 32'(state_dbg), 32'(ST_IDLE));

        // Reset mid-run
        fill_body();
        bus.snake_length = LEN_BITS'(4);
        bus.food_pos     = POS_BITS'(HEAD);
        dc = done_count;
        pulse_start();
        @(negedge clk);
        check("abort food_hit_pre", 32'(bus.food_hit), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 32'(bus.busy), 0);
        check("abort food_hit", 32'(bus.food_hit), 0);
        check("abort self_hit", 32'(bus.self_hit), 0);
        check("abort state", 32'(state_dbg), 32'(ST_IDLE));
        repeat (8) @(negedge clk);
        check("abort no done", done_count - dc, 0);
        drive_start(4, HEAD, 1'b1, 1'b0, 5);
        wait_done("after_abort", 0);

        // Random lengths and hit positions
        for (int n = 0; n < 6; n++) begin
            fill_body();
            len = $urandom_range(2, 12);
            j   = $urandom_range(1, len);
            fh  = 1'($urandom_range(0, 1));
            if (j < len) set_seg(j, HEAD);
            drive_start(len, fh ? HEAD : 5, fh, (j < len), (j < len) ? j + 2 : len + 1);
            wait_done("random", 0);
        end

        check("queue empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got no finish expected finish within 2 ms");
        $fatal(1, "global timeout");
    end
endmodule
